keypad_scan: RTL and testbench

Scanner for a 4x4 passive matrix keypad, the input-side counterpart of the multiplexed two-digit display driver.
- Drives one row low at a time and samples the four column lines, which are pulled up externally.
- Debounces a press and reports one key code per press.
- Keeps a two-digit shift buffer whose 8-bit format feeds the display driver's pp input directly.

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_scan_tick.sv | 37 +++
 rtl/keypad_scan.sv | 176 +++++++++++++++++
 tb/tb_keypad_scan.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared constants for the 4x4 keypad scanner: FSM state
//             encoding, idle row drive and key code width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

    localparam int KEY_W = 4;

    localparam logic [1:0] SCAN      = 2'd0;
    localparam logic [1:0] DEB_PRESS = 2'd1;
    localparam logic [1:0] PRESSED   = 2'd2;
    localparam logic [1:0] DEB_REL   = 2'd3;

    // All rows released (rows are driven active low)
    localparam logic [3:0] ROW_IDLE = 4'b1111;

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_scan_tick.sv
`default_nettype none
// ============================================================================
//  Module   : scan_tick
//  Purpose  : Free-running row-dwell prescaler. Counts 0..SCAN_DIV-1 and
//             wraps; o_tick is high on the last count of every dwell.
//  Ports    : clk_e   - system clock
//             rst     - asynchronous active-low reset
//             o_tick  - one-cycle strobe at the end of each dwell
//  Revision : 1.0  initial release
// ============================================================================
module scan_tick #(
    parameter int SCAN_DIV = 5000
) (
    input  logic clk_e,
    input  logic rst,
    output logic o_tick
);

    localparam int             CW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] r_div_cnt;

    always_ff @(posedge clk_e or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == C_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign o_tick = (r_div_cnt == C_LAST);

endmodule : scan_tick
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan
//  Purpose  : 4x4 passive matrix keypad scanner. Walks a single low row,
//             samples the pulled-up columns at the end of each dwell,
//             debounces press and release, and reports one code per press.
//             digits is a two-key shift buffer in display-driver format.
//  Ports    : clk_e     - system clock
//             rst       - asynchronous active-low reset
//             row       - row drive, active low (4'b1111 in reset)
//             col       - column sense, active low, asynchronous
//             key_code  - last accepted key {row_idx, col_idx}
//             key_valid - one-cycle pulse per accepted key
//             key_held  - high from acceptance until release is debounced
//             digits    - {previous key_code, latest key_code}
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scan #(
    parameter int SCAN_DIV = 5000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk_e,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [7:0] digits
);

    import keypad_pkg::*;

    localparam int            DW          = $clog2(DEBOUNCE + 1);
    // deb_cnt holds the number of samples already seen, so the sample that
    // makes it reach DEBOUNCE arrives while it still reads DEBOUNCE-1.
    localparam logic [DW-1:0] C_DEB_LAST  = DW'(DEBOUNCE - 1);
    localparam logic          C_DEB_ONE   = (DEBOUNCE == 1);

    logic [3:0]       r_col_meta;
    logic [3:0]       r_col_s;
    logic [1:0]       r_row_idx;
    logic [1:0]       r_state;
    logic [DW-1:0]    r_deb_cnt;
    logic [KEY_W-1:0] r_cand;
    logic [3:0]       r_row;
    logic [KEY_W-1:0] r_key_code;
    logic             r_key_valid;
    logic             r_key_held;
    logic [7:0]       r_digits;

    logic             w_tick;
    logic             w_hit;
    logic [1:0]       w_col_idx;
    logic             w_match;
    logic             w_accept;
    logic             w_release;
    logic [KEY_W-1:0] w_accept_code;

    scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk_e  (clk_e),
        .rst    (rst),
        .o_tick (w_tick)
    );

    // Two-flop synchronizer; idles as "no key" so reset never fakes a hit.
    always_ff @(posedge clk_e or negedge rst) begin
        if (!rst) begin
            r_col_meta <= 4'hF;
            r_col_s    <= 4'hF;
        end else begin
            r_col_meta <= col;
            r_col_s    <= r_col_meta;
        end
    end

    // Lowest-numbered low column wins.
    always_comb begin
        w_col_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_col_s[i]) begin
                w_col_idx = 2'(i);
            end
        end
    end

    assign w_hit   = ~&r_col_s;
    assign w_match = w_hit && (w_col_idx == r_cand[1:0]);

    // A single-sample debounce accepts straight from SCAN; otherwise the
    // candidate latched on entry to DEB_PRESS is the one reported.
    assign w_accept_code = (r_state == SCAN) ? {r_row_idx, w_col_idx} : r_cand;
    assign w_accept  = w_tick &&
                       (((r_state == SCAN) && w_hit && C_DEB_ONE) ||
                        ((r_state == DEB_PRESS) && w_match && (r_deb_cnt == C_DEB_LAST)));
    assign w_release = w_tick && !w_hit &&
                       (((r_state == PRESSED) && C_DEB_ONE) ||
                        ((r_state == DEB_REL) && (r_deb_cnt == C_DEB_LAST)));

    always_ff @(posedge clk_e or negedge rst) begin
        if (!rst) begin
            r_row_idx   <= 2'd0;
            r_state     <= SCAN;
            r_deb_cnt   <= '0;
            r_cand      <= '0;
            r_row       <= ROW_IDLE;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_digits    <= 8'h00;
        end else begin
            r_key_valid <= 1'b0;
            // Row output lags row_idx by one cycle; the dwell is long
            // enough to cover this plus the synchronizer delay.
            r_row       <= ~(4'b0001 << r_row_idx);

            if (w_accept) begin
                r_cand      <= w_accept_code;
                r_key_code  <= w_accept_code;
                r_digits    <= {r_digits[3:0], w_accept_code};
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                r_state     <= PRESSED;
            end else if (w_release) begin
                r_key_held <= 1'b0;
                r_row_idx  <= r_row_idx + 1'b1;
                r_state    <= SCAN;
            end else if (w_tick) begin
                case (r_state)
                    SCAN: begin
                        if (w_hit) begin
                            r_cand    <= {r_row_idx, w_col_idx};
                            r_deb_cnt <= DW'(1);
                            r_state   <= DEB_PRESS;
                        end else begin
                            r_row_idx <= r_row_idx + 1'b1;
                        end
                    end
                    DEB_PRESS: begin
                        if (w_match) begin
                            r_deb_cnt <= r_deb_cnt + 1'b1;
                        end else begin
                            r_row_idx <= r_row_idx + 1'b1;
                            r_state   <= SCAN;
                        end
                    end
                    PRESSED: begin
                        if (!w_hit) begin
                            r_deb_cnt <= DW'(1);
                            r_state   <= DEB_REL;
                        end
                    end
                    DEB_REL: begin
                        if (!w_hit) begin
                            r_deb_cnt <= r_deb_cnt + 1'b1;
                        end else begin
                            // Release bounce: back to held, no new report.
                            r_state <= PRESSED;
                        end
                    end
                    default: r_state <= SCAN;
                endcase
            end
        end
    end

    assign row       = r_row;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign digits    = r_digits;

endmodule : keypad_scan
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scan
//  Purpose  : Self-checking bench for keypad_scan with a behavioural 4x4
//             key matrix and a key-report scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;

    logic        clk_e = 1'b0;
    logic        rst   = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [7:0]  digits;
    logic [15:0] keys  = '0;   // bit r*4+c set = key at row r, column c pressed

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk_e     (clk_e),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .digits    (digits)
    );

    always #5 clk_e = ~clk_e;

    // Passive matrix: a pressed key shorts its column to its row when that
    // row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && keys[r*4+c]) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    int n_cmp   = 0;
    int n_err   = 0;
    int n_valid = 0;

    typedef struct packed {
        logic [3:0] code;
        logic [7:0] dig;
    } exp_t;

    exp_t       q[$];
    exp_t       m_e;
    logic [7:0] exp_digits = 8'h00;

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  code;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_e);
    endtask

    task automatic push_exp(input logic [3:0] code);
        exp_digits = {exp_digits[3:0], code};
        q.push_back('{code: code, dig: exp_digits});
    endtask

    task automatic chk_drained(input string name);
        chk(name, q.size(), 0);
        q.delete();
    endtask

    // Scoreboard: every key_valid pulse must match the oldest expected press.
    always @(negedge clk_e) begin
        if (rst && key_valid) begin
            n_valid++;
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_key_valid: got key_code=%0h digits=%0h, expected no pulse",
                         key_code, digits);
            end else begin
                m_e = q.pop_front();
                chk("key_code", 32'(key_code), 32'(m_e.code));
                chk("digits", 32'(digits), 32'(m_e.dig));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        int         base;
        int         idx;
        logic [3:0] er;

        vt[0] = '{16'h0200, 4'h9};   // row2/col1
        vt[1] = '{16'h4000, 4'hE};   // row3/col2
        vt[2] = '{16'h0060, 4'h5};   // row1 col1+col2: lower column wins
        vt[3] = '{16'h0008, 4'h3};   // row0/col3
        vt[4] = '{16'h1000, 4'hC};   // row3/col0

        // Reset state
        rst  = 1'b0;
        keys = '0;
        cycles(3);
        chk("reset_row", 32'(row), 32'h0F);
        chk("reset_key_code", 32'(key_code), 32'h0);
        chk("reset_key_valid", 32'(key_valid), 32'h0);
        chk("reset_key_held", 32'(key_held), 32'h0);
        chk("reset_digits", 32'(digits), 32'h00);

        // Idle scan: each row low for SCAN_DIV cycles, starting at row 0
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_e);
            idx = ((k - 1) / SCAN_DIV) % 4;
            er  = ~(4'b0001 << idx);
            chk("idle_row", 32'(row), 32'(er));
        end
        chk("idle_no_valid", n_valid, 0);
        chk("idle_digits", 32'(digits), 32'h00);

        // Clean presses from the vector table
        for (int i = 0; i < 5; i++) begin
            keys = vt[i].keys;
            push_exp(vt[i].code);
            cycles(60);
            chk_drained("press_reported");
            chk("held_after_press", 32'(key_held), 32'h1);
            keys = '0;
            cycles(8);
            chk("held_during_rel_deb", 32'(key_held), 32'h1);
            cycles(30);
            chk("held_released", 32'(key_held), 32'h0);
            chk("code_holds", 32'(key_code), 32'(vt[i].code));
        end

        // Bouncy press and bouncy release: exactly one report
        base = n_valid;
        push_exp(4'h9);
        repeat (5) begin
            keys = 16'h0200; cycles(2);
            keys = 16'h0000; cycles(2);
        end
        keys = 16'h0200;
        cycles(60);
        chk_drained("bounce_reported");
        chk("bounce_one_pulse", n_valid - base, 1);
        chk("bounce_code", 32'(key_code), 32'h9);
        repeat (5) begin
            keys = 16'h0000; cycles(2);
            keys = 16'h0200; cycles(2);
        end
        keys = '0;
        cycles(40);
        chk("rel_bounce_no_pulse", n_valid - base, 1);
        chk("rel_bounce_released", 32'(key_held), 32'h0);

        // Second key in another row while one is held
        base = n_valid;
        keys = 16'h0001;
        push_exp(4'h0);
        cycles(60);
        chk_drained("held_first_reported");
        keys = 16'h0081;
        cycles(60);
        chk("other_row_ignored", n_valid - base, 1);
        chk("other_row_code", 32'(key_code), 32'h0);
        keys = 16'h0080;
        push_exp(4'h7);
        cycles(60);
        chk_drained("rescan_reported");
        chk("rescan_code", 32'(key_code), 32'h7);
        keys = '0;
        cycles(40);

        // Reset mid-debounce with the key held through reset
        keys = 16'h0001;
        rst  = 1'b0;
        cycles(2);
        chk("rst2_key_code", 32'(key_code), 32'h0);
        chk("rst2_digits", 32'(digits), 32'h00);
        q.delete();
        exp_digits = 8'h00;
        base = n_valid;
        rst  = 1'b1;
        cycles(6);          // detected at tick 1, now inside DEB_PRESS
        #1 rst = 1'b0;
        #1;
        chk("async_rst_row", 32'(row), 32'h0F);
        chk("async_rst_valid", 32'(key_valid), 32'h0);
        chk("async_rst_held", 32'(key_held), 32'h0);
        cycles(2);
        chk("mid_deb_no_pulse", n_valid - base, 0);
        push_exp(4'h0);
        rst = 1'b1;
        cycles(40);
        chk_drained("held_thru_reset_reported");
        chk("held_thru_reset_one_pulse", n_valid - base, 1);
        chk("held_thru_reset_held", 32'(key_held), 32'h1);
        keys = '0;
        cycles(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_keypad_scan
`default_nettype wire
